core_seq_ctrl: RTL and testbench
================================

// Module: core_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the core. Generates the one-hot state bus that drives the
//  fetch, execute and writeback stages, and owns the single shared memory port.
//  Instruction fetch and load/store take turns on that port with a req/gnt handshake.
//  A stall watchdog bounds every wait for a grant.
//  Retired instructions are counted.
// PARAMETERS
//  TIMEOUT_W   8    width of the stall watchdog counter
//  TIMEOUT     255  number of ungranted wait cycles before bus_err fires (must be < 2**TIMEOUT_W)
// PORTS
//  clk          in   1   core clock
//  rstn         in   1   asynchronous reset, active low
//  is_load      in   1   decoder: current instruction is a load (valid in EX)
//  is_store     in   1   decoder: current instruction is a store (valid in EX)
//  rd_wen_dec   in   1   decoder: instruction writes rd (valid in EX, held until WB)
//  mem_gnt      in   1   memory accepted the current request this cycle
//  state        out  4   one-hot `StateBus: bit `IF, `EX, `MEM, `WB
//  mem_req      out  1   memory request
//  mem_we       out  1   memory write (store)
//  mem_addr_sel out  1   address mux select: 0 = PC (fetch), 1 = ALU result (data)
//  pc_we        out  1   PC update strobe
//  rd_we        out  1   register-file write strobe
//  bus_err      out  1   one-cycle pulse: watchdog expired
//  instret      out  32  retired-instruction count, wraps modulo 2**32
// BEHAVIOUR
//  Reset (rstn low):
//   - state = one-hot IF; wait_cnt = 0; instret = 0; latched rd_wen = 0.
//   - All strobes are 0. mem_req is gated low while rstn is low.
//  Memory protocol:
//   - Read data is valid on mem_rdata exactly one cycle after the cycle of mem_req & mem_gnt.
//  IF:
//   - Drive mem_req=1, mem_addr_sel=0, mem_we=0.
//   - mem_gnt=1 -> EX next cycle; otherwise stay in IF.
//  EX (always exactly 1 cycle):
//   - The instruction is on mem_rdata this cycle and the fetch stage captures it here.
//   - Latch rd_wen_dec.
//   - is_load | is_store -> MEM; otherwise -> WB.
//   - is_load & is_store together is treated as a store.
//  MEM:
//   - Drive mem_req=1, mem_addr_sel=1, mem_we=latched is_store.
//   - mem_gnt=1 -> WB; otherwise stay in MEM.
//  WB (always exactly 1 cycle):
//   - pc_we=1; rd_we = latched rd_wen & ~abort; instret += 1 unless abort.
//   - Next state is IF.
//   - Load data arrives in this cycle, one cycle after the MEM grant.
//  Outputs mem_req, mem_we, mem_addr_sel, pc_we and rd_we are combinational from state and latches.
//  Watchdog:
//   - wait_cnt counts cycles spent in IF or MEM with mem_gnt=0.
//   - Clears on every state change and on any grant.
//   - Fires when wait_cnt == TIMEOUT and mem_gnt=0: bus_err=1 for that cycle.
//      - In IF: stay in IF, clear wait_cnt, retry the fetch.
//      - In MEM: go to WB with abort=1 (no rd_we, no instret increment, pc_we still 1).
//   - abort clears on leaving WB.
//   - mem_gnt=1 in the expiry cycle: the grant wins, no bus_err.
//  State is always one-hot. Any illegal encoding recovers to IF on the next cycle.
//  Reset mid-access: the memory request is dropped and execution restarts in IF.
// STRUCTURE
//  defines.v:
//   - `StateBus 3:0
//   - `IF 0, `EX 1, `MEM 2, `WB 3
//   - `ST_RESET 4'b0001
//   - `ADDR_SEL_PC 1'b0, `ADDR_SEL_DATA 1'b1
//  The state register uses the existing DFF with set_data = `ST_RESET.
//  One sub-module: seq_wait_timer (counter, clear, expiry compare).
// TESTING
//  1. ALU op, gnt always 1:
//     - state IF,EX,WB repeats with a 3-cycle period.
//     - pc_we and rd_we in WB; instret +1 per instruction.
//  2. Load, gnt=1:
//     - IF,EX,MEM,WB; mem_addr_sel=1 and mem_we=0 in MEM.
//     - rd_we=1 in WB with rdata captured.
//  3. Store with gnt withheld 5 cycles in MEM:
//     - Stays in MEM for 6 cycles with mem_we=1.
//     - WB has rd_we=0; instret +1.
//  4. TIMEOUT=4, gnt=0 in IF:
//     - bus_err pulses at the 5th waiting cycle, state stays IF.
//     - With gnt=1 on that same cycle there is no bus_err and the next state is EX.
//  5. TIMEOUT=4, gnt=0 in MEM for a load:
//     - bus_err, then WB with rd_we=0, pc_we=1, instret unchanged, then IF.
//  6. Assert rstn low during MEM:
//     - Outputs clear asynchronously and mem_req=0.
//     - After release: state=IF, instret=0.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared encodings for the core sequencer: one-hot state bus, address-mux selects
// and the bundle of memory/pipeline strobes the sequencer drives.
package core_seq_pkg;

  localparam int STATE_W = 4;

  typedef logic [STATE_W-1:0] state_bus_t;

  localparam state_bus_t ST_IF    = 4'b0001;
  localparam state_bus_t ST_EX    = 4'b0010;
  localparam state_bus_t ST_MEM   = 4'b0100;
  localparam state_bus_t ST_WB    = 4'b1000;
  localparam state_bus_t ST_RESET = ST_IF;

  localparam logic ADDR_SEL_PC   = 1'b0;
  localparam logic ADDR_SEL_DATA = 1'b1;

  typedef struct packed {
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic pc_we;
    logic rd_we;
  } ctrl_t;

endpackage

// File: rtl/core_seq_ctrl_wait_timer.sv
// Stall watchdog for the shared memory port: counts ungranted wait cycles and
// flags expiry when the count reaches TIMEOUT with the grant still low.
module seq_wait_timer #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_active,
  input  logic i_gnt,
  input  logic i_state_chg,
  output logic o_expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT);

  logic [TIMEOUT_W-1:0] r_count;
  logic                 w_clear;

  assign o_expired = i_active & ~i_gnt & (r_count == LIMIT);

  // An expiry restarts the count so a retried fetch gets a full new window.
  assign w_clear = ~i_active | i_gnt | i_state_chg | o_expired;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (w_clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + TIMEOUT_W'(1);
    end
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle core sequencer: one-hot IF/EX/MEM/WB bus, shared memory port
// arbitration by state, stall watchdog and retired-instruction counter.
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               is_load,
  input  logic               is_store,
  input  logic               rd_wen_dec,
  input  logic               mem_gnt,
  output logic [STATE_W-1:0] state,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_addr_sel,
  output logic               pc_we,
  output logic               rd_we,
  output logic               bus_err,
  output logic [31:0]        instret
);

  state_bus_t  r_state;
  state_bus_t  w_state_nxt;
  logic        r_rd_wen;
  logic        r_is_store;
  logic        r_abort;
  logic [31:0] r_instret;

  logic  w_in_if;
  logic  w_in_ex;
  logic  w_in_mem;
  logic  w_in_wb;
  logic  w_state_chg;
  logic  w_expired;
  ctrl_t w_ctrl;

  assign w_in_if     = (r_state == ST_IF);
  assign w_in_ex     = (r_state == ST_EX);
  assign w_in_mem    = (r_state == ST_MEM);
  assign w_in_wb     = (r_state == ST_WB);
  assign w_state_chg = (r_state != w_state_nxt);

  seq_wait_timer #(
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_wait_timer (
    .clk         (clk),
    .rstn        (rstn),
    .i_active    (w_in_if | w_in_mem),
    .i_gnt       (mem_gnt),
    .i_state_chg (w_state_chg),
    .o_expired   (w_expired)
  );

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch
    // is inferred; it also sends any illegal encoding back to IF.
    w_state_nxt = ST_RESET;
    case (r_state)
      ST_IF:  w_state_nxt = mem_gnt ? ST_EX : ST_IF;
      ST_EX:  w_state_nxt = (is_load | is_store) ? ST_MEM : ST_WB;
      ST_MEM: w_state_nxt = (mem_gnt | w_expired) ? ST_WB : ST_MEM;
      ST_WB:  w_state_nxt = ST_IF;
      default: w_state_nxt = ST_RESET;
    endcase
  end

  always_comb begin
    w_ctrl              = '0;
    w_ctrl.mem_addr_sel = ADDR_SEL_PC;
    case (r_state)
      ST_IF: begin
        w_ctrl.mem_req = 1'b1;
      end
      ST_MEM: begin
        w_ctrl.mem_req      = 1'b1;
        w_ctrl.mem_we       = r_is_store;
        w_ctrl.mem_addr_sel = ADDR_SEL_DATA;
      end
      ST_WB: begin
        w_ctrl.pc_we = 1'b1;
        w_ctrl.rd_we = r_rd_wen & ~r_abort;
      end
      default: ;
    endcase
  end

  // Decoder qualifiers are only trusted in EX; a load+store pair behaves as a store.
  // The abort flag is set on the MEM expiry edge and drops again as WB is left.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_wen   <= 1'b0;
      r_is_store <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      if (w_in_ex) begin
        r_rd_wen   <= rd_wen_dec;
        r_is_store <= is_store;
      end
      r_abort <= w_in_mem & w_expired;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_instret <= '0;
    end else if (w_in_wb && !r_abort) begin
      r_instret <= r_instret + 32'd1;
    end
  end

  assign state        = r_state;
  assign mem_req      = w_ctrl.mem_req & rstn;
  assign mem_we       = w_ctrl.mem_we;
  assign mem_addr_sel = w_ctrl.mem_addr_sel;
  assign pc_we        = w_ctrl.pc_we;
  assign rd_we        = w_ctrl.rd_we;
  assign bus_err      = w_expired & rstn;
  assign instret      = r_instret;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: each instruction is described by its kind and grant
// delays, and the expected cycle trace is built from that description.
module tb_core_seq_ctrl;

  localparam int TW = 8;
  localparam int TO = 4;

  localparam logic [3:0] S_IF  = 4'b0001;
  localparam logic [3:0] S_EX  = 4'b0010;
  localparam logic [3:0] S_MEM = 4'b0100;
  localparam logic [3:0] S_WB  = 4'b1000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        is_load;
  logic        is_store;
  logic        rd_wen_dec;
  logic        mem_gnt;
  logic [3:0]  state;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        pc_we;
  logic        rd_we;
  logic        bus_err;
  logic [31:0] instret;

  typedef struct packed {
    logic [3:0]  st;
    logic        req;
    logic        we;
    logic        sel;
    logic        pc;
    logic        rd;
    logic        err;
    logic [31:0] ret;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        act_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_instret = '0;

  always #5 clk = ~clk;

  core_seq_ctrl #(
    .TIMEOUT_W (TW),
    .TIMEOUT   (TO)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .is_load      (is_load),
    .is_store     (is_store),
    .rd_wen_dec   (rd_wen_dec),
    .mem_gnt      (mem_gnt),
    .state        (state),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .pc_we        (pc_we),
    .rd_we        (rd_we),
    .bus_err      (bus_err),
    .instret      (instret)
  );

  function automatic obs_t observe();
    obs_t o;
    o = {state, mem_req, mem_we, mem_addr_sel, pc_we, rd_we, bus_err, instret};
    return o;
  endfunction

  function automatic obs_t mk(input logic [3:0] s, input logic req, we, sel, pc, rd, err);
    obs_t o;
    o = {s, req, we, sel, pc, rd, err, m_instret};
    return o;
  endfunction

  // One clock: record expected and observed at the falling edge, then move
  // to just after the next rising edge where the following inputs are driven.
  task automatic step(input obs_t e);
    @(negedge clk);
    exp_q.push_back(e);
    act_q.push_back(observe());
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction. if_wait / mem_wait are the ungranted cycles before
  // the grant; a wait longer than TO in MEM ends in an abort.
  task automatic run_instr(input logic ld, st, rw, input int if_wait, mem_wait);
    logic abort;
    int   n;
    logic err;
    abort      = 1'b0;
    rd_wen_dec = rw;
    for (int k = 0; k <= if_wait; k++) begin
      mem_gnt  = (k == if_wait);
      is_load  = 1'($urandom);
      is_store = 1'($urandom);
      err      = !mem_gnt && ((k % (TO + 1)) == TO);
      step(mk(S_IF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, err));
    end
    is_load  = ld;
    is_store = st;
    mem_gnt  = 1'($urandom);
    step(mk(S_EX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    if (ld || st) begin
      n = (mem_wait > TO) ? TO : mem_wait;
      for (int k = 0; k <= n; k++) begin
        mem_gnt  = (mem_wait <= TO) && (k == n);
        is_load  = 1'($urandom);
        is_store = 1'($urandom);
        err      = !mem_gnt && (k == TO);
        if (err) abort = 1'b1;
        step(mk(S_MEM, 1'b1, st, 1'b1, 1'b0, 1'b0, err));
      end
    end
    mem_gnt  = 1'($urandom);
    is_load  = 1'($urandom);
    is_store = 1'($urandom);
    step(mk(S_WB, 1'b0, 1'b0, 1'b0, 1'b1, rw & ~abort, 1'b0));
    if (!abort) m_instret = m_instret + 32'd1;
  endtask

  task automatic clear_trace();
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic test_reset();
    obs_t e;
    rstn = 1'b0; is_load = 1'b0; is_store = 1'b0; rd_wen_dec = 1'b1; mem_gnt = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_instret = '0;
    e = mk(S_IF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (observe() !== e) begin
      n_fail++;
      $display("FAIL reset_state: got %h, expected %h", observe(), e);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_alu();
    clear_trace();
    for (int i = 0; i < 4; i++) run_instr(1'b0, 1'b0, 1'b1, 0, 0);
    run_instr(1'b0, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (act_q.size() != 15) begin
      n_fail++;
      $display("FAIL alu_period: got %0d cycles, expected 15", act_q.size());
    end
    foreach (act_q[i]) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL alu cyc %0d: got %h, expected %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_load();
    clear_trace();
    run_instr(1'b1, 1'b0, 1'b1, 0, 0);
    run_instr(1'b1, 1'b0, 1'b1, 2, 1);
    run_instr(1'b1, 1'b1, 1'b1, 0, 0);
    foreach (act_q[i]) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL load cyc %0d: got %h, expected %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_store_wait();
    clear_trace();
    run_instr(1'b0, 1'b1, 1'b0, 0, TO);
    run_instr(1'b0, 1'b1, 1'b0, 1, 2);
    foreach (act_q[i]) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL store_wait cyc %0d: got %h, expected %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_if_timeout();
    clear_trace();
    run_instr(1'b0, 1'b0, 1'b1, TO + 1, 0);
    run_instr(1'b0, 1'b0, 1'b1, TO, 0);
    run_instr(1'b1, 1'b0, 1'b1, 3 * (TO + 1) - 1, 0);
    foreach (act_q[i]) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL if_timeout cyc %0d: got %h, expected %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mem_timeout();
    clear_trace();
    run_instr(1'b1, 1'b0, 1'b1, 0, TO + 5);
    run_instr(1'b0, 1'b1, 1'b1, 0, TO + 1);
    run_instr(1'b0, 1'b0, 1'b1, 0, 0);
    foreach (act_q[i]) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mem_timeout cyc %0d: got %h, expected %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    clear_trace();
    for (int i = 0; i < 40; i++) begin
      run_instr(1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 2 * TO + 2)), int'($urandom_range(0, TO + 3)));
    end
    foreach (act_q[i]) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h, expected %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    clear_trace();
    rd_wen_dec = 1'b1; is_load = 1'b0; is_store = 1'b0; mem_gnt = 1'b1;
    step(mk(S_IF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    is_load = 1'b1; mem_gnt = 1'b0;
    step(mk(S_EX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step(mk(S_MEM, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    step(mk(S_MEM, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    rstn = 1'b0;
    #2;
    m_instret = '0;
    exp_q.push_back(mk(S_IF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    act_q.push_back(observe());
    @(posedge clk);
    #1;
    rstn = 1'b1;
    run_instr(1'b0, 1'b0, 1'b1, 0, 0);
    run_instr(1'b1, 1'b0, 1'b1, 1, 1);
    foreach (act_q[i]) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_mid_mem cyc %0d: got %h, expected %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_wait();
    test_if_timeout();
    test_mem_timeout();
    test_random();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
